// File: rtl/maxpool_flatten.sv
// maxpool_flatten
//   Reads two 64x64 layer-0 feature maps from the shared result memory,
//   applies 2x2 stride-2 max-pooling, and writes each pooled value to the
//   32x32 layer-1 map of its kernel and to the interleaved layer-2 flatten
//   buffer (k0,k1 per pixel).
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle request to begin a full pass (ignored while busy/DONE)
//   busy      high while a pass is in progress
//   done      one-cycle pulse after the final write
//   crd       memory read enable
//   caddr_rd  memory read address
//   cdata_rd  read data, sampled at the edge closing the read cycle
//   cwr       memory write enable
//   caddr_wr  memory write address
//   cdata_wr  memory write data
//   csel      bank select (001/010 L0, 011/100 L1, 101 L2, 000 idle)
module maxpool_flatten (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic [2:0]  csel
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CMP, S_WL1, S_WL2, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;      // {k, r[4:0], c[4:0]}; k outermost
    logic [19:0] max_q, max_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        crd_q, crd_d;
    logic [11:0] caddr_rd_q, caddr_rd_d;
    logic        cwr_q, cwr_d;
    logic [11:0] caddr_wr_q, caddr_wr_d;
    logic [19:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]  csel_q, csel_d;

    // Window coordinates of the state being entered; outputs are registered
    // from the next state so they line up with it.
    logic       nk;
    logic [4:0] nr, nc;
    assign nk = idx_d[10];
    assign nr = idx_d[9:5];
    assign nc = idx_d[4:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        max_d   = max_q;

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RD0;
                idx_d   = '0;
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_RD3;
            S_RD3:  state_d = S_CMP;
            S_CMP:  state_d = S_WL1;
            S_WL1:  state_d = S_WL2;
            S_WL2: begin
                if (idx_q == 11'h7FF) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    state_d = S_RD0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The edge closing each read cycle carries that read's sample.
        // The first sample loads the running max; later ones compete
        // unsigned against it.
        case (state_q)
            S_RD0:               max_d = cdata_rd;
            S_RD1, S_RD2, S_RD3: if (cdata_rd > max_q) max_d = cdata_rd;
            default: ;
        endcase
    end

    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = 3'b000;
        caddr_rd_d = '0;
        caddr_wr_d = '0;
        cdata_wr_d = '0;

        case (state_d)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                busy_d = 1'b1;
                crd_d  = 1'b1;
                csel_d = nk ? 3'b010 : 3'b001;
                // Base (2r)*64 + 2c; bit 6 picks the lower row, bit 0 the right column.
                case (state_d)
                    S_RD0:   caddr_rd_d = {nr, 1'b0, nc, 1'b0};
                    S_RD1:   caddr_rd_d = {nr, 1'b0, nc, 1'b1};
                    S_RD2:   caddr_rd_d = {nr, 1'b1, nc, 1'b0};
                    default: caddr_rd_d = {nr, 1'b1, nc, 1'b1};
                endcase
            end
            S_CMP: begin
                busy_d = 1'b1;
                csel_d = nk ? 3'b010 : 3'b001;
            end
            S_WL1: begin
                busy_d     = 1'b1;
                cwr_d      = 1'b1;
                csel_d     = nk ? 3'b100 : 3'b011;
                caddr_wr_d = {2'b00, nr, nc};
                cdata_wr_d = max_q;
            end
            S_WL2: begin
                busy_d     = 1'b1;
                cwr_d      = 1'b1;
                csel_d     = 3'b101;
                caddr_wr_d = {1'b0, nr, nc, nk};   // 2*(r*32+c)+k
                cdata_wr_d = max_q;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            max_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            caddr_rd_q <= '0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_maxpool_flatten.sv
// Self-checking bench for maxpool_flatten: a memory model answers reads,
// a write logger fills L1/L2 images, and results are compared against a
// software max-pool model and a table of hand-computed windows.
module tb_maxpool_flatten;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, crd, cwr;
    logic [11:0] caddr_rd, caddr_wr;
    logic [19:0] cdata_rd, cdata_wr;
    logic [2:0]  csel;

    always #5 clk = ~clk;

    maxpool_flatten dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
    );

    logic [19:0] l0 [2][4096];
    logic [19:0] l1 [2][1024];
    logic [19:0] l2 [2048];

    // Read data is only meaningful during a read; otherwise drive a large
    // value so that a capture at the wrong time corrupts the max.
    assign cdata_rd = (crd && csel == 3'b001) ? l0[0][caddr_rd] :
                      (crd && csel == 3'b010) ? l0[1][caddr_rd] : 20'hFFFFF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nwr_l1 = 0, nwr_l2 = 0, bad_wr = 0, bad_order = 0;
    int          last_l1_cyc = -10;
    logic [11:0] last_l1_addr = '0;
    logic        last_k = 1'b0;
    logic [19:0] last_data = '0;
    bit          clr_req = 1'b0;

    always @(negedge clk) begin : logger
        int b;
        int kk;
        b = 0;
        if (clr_req) begin
            for (int i = 0; i < 1024; i++) begin
                l1[0][i] <= 20'h5A5A5;
                l1[1][i] <= 20'h5A5A5;
            end
            for (int i = 0; i < 2048; i++) l2[i] <= 20'h5A5A5;
            nwr_l1 <= 0; nwr_l2 <= 0; bad_wr <= 0; bad_order <= 0;
            last_l1_cyc <= -10;
        end else begin
            if (crd && (!busy || (csel != 3'b001 && csel != 3'b010))) b++;
            if (cwr) begin
                if (crd || !busy) b++;
                case (csel)
                    3'b011, 3'b100: begin
                        kk = (csel == 3'b100) ? 1 : 0;
                        if (caddr_wr > 12'd1023) b++;
                        else l1[kk][caddr_wr[9:0]] <= cdata_wr;
                        nwr_l1       <= nwr_l1 + 1;
                        last_l1_cyc  <= cyc;
                        last_l1_addr <= caddr_wr;
                        last_k       <= (kk == 1);
                        last_data    <= cdata_wr;
                    end
                    3'b101: begin
                        if (caddr_wr > 12'd2047) b++;
                        else l2[caddr_wr[10:0]] <= cdata_wr;
                        nwr_l2 <= nwr_l2 + 1;
                        // L2 write must directly follow its L1 write, same data,
                        // at the interleaved address.
                        if (last_l1_cyc != cyc - 1 || caddr_wr != {last_l1_addr[10:0], last_k} ||
                            cdata_wr != last_data)
                            bad_order <= bad_order + 1;
                    end
                    default: b++;
                endcase
            end
            if (b != 0) bad_wr <= bad_wr + b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        @(posedge clk);
        clr_req = 1'b0;
    endtask

    // Starts a pass and follows it to DONE (or until reset_at aborts it).
    task automatic run_pass(input string name, input int again_at, input int reset_at,
                            output int busy_cycles, output int done_at, output bit aborted);
        int  n;
        bit  got;
        busy_cycles = 0; done_at = -1; aborted = 1'b0; got = 1'b0; n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < 20000) begin
            if (n == reset_at) begin
                #2 reset = 1'b0;
                #1;
                chk({name, "_rst_crd"},  64'(crd),  64'd0);
                chk({name, "_rst_cwr"},  64'(cwr),  64'd0);
                chk({name, "_rst_busy"}, 64'(busy), 64'd0);
                @(negedge clk);
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_at = n;
                got = 1'b1;
                start = 1'b1;       // start during DONE must be ignored
                break;
            end
            start = (n == again_at);
            @(negedge clk);
            n++;
        end
        if (!aborted) begin
            if (!got) begin
                chk({name, "_timeout"}, 64'd1, 64'd0);
            end else begin
                @(negedge clk);
                start = 1'b0;
                chk({name, "_after_done_busy"}, 64'(busy), 64'd0);
                chk({name, "_done_single"},     64'(done), 64'd0);
            end
        end
        start = 1'b0;
    endtask

    task automatic pass_checks(input string name, input int busy_cycles, input int done_at);
        chk({name, "_busy_cycles"}, 64'(busy_cycles), 64'd14336);
        chk({name, "_done_at"},     64'(done_at),     64'd14336);
        chk({name, "_nwr_l1"},      64'(nwr_l1),      64'd2048);
        chk({name, "_nwr_l2"},      64'(nwr_l2),      64'd2048);
        chk({name, "_bad_wr"},      64'(bad_wr),      64'd0);
        chk({name, "_bad_order"},   64'(bad_order),   64'd0);
    endtask

    // Software model: 2x2 stride-2 unsigned max over both L0 banks.
    task automatic cmp_all(input string name);
        int m1, m2, a, o;
        logic [19:0] mx;
        m1 = 0; m2 = 0;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 32; c++) begin
                    a  = r * 128 + c * 2;
                    o  = r * 32 + c;
                    mx = l0[k][a];
                    if (l0[k][a + 1]  > mx) mx = l0[k][a + 1];
                    if (l0[k][a + 64] > mx) mx = l0[k][a + 64];
                    if (l0[k][a + 65] > mx) mx = l0[k][a + 65];
                    if (l1[k][o] !== mx) m1++;
                    if (l2[2 * o + k] !== mx) m2++;
                end
        chk({name, "_l1_mismatches"}, 64'(m1), 64'd0);
        chk({name, "_l2_mismatches"}, 64'(m2), 64'd0);
    endtask

    typedef struct {
        int          k, r, c;
        logic [19:0] s0, s1, s2, s3;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int bc, da, b, o;
        bit ab;

        tbl[0] = '{0,  0,  0, 20'h00010, 20'h00030, 20'h00020, 20'h00005, 20'h00030};
        tbl[1] = '{1, 31, 31, 20'h00001, 20'h00002, 20'h00003, 20'h7FFFF, 20'h7FFFF};
        tbl[2] = '{0,  1,  0, 20'hFFFFF, 20'h00001, 20'h00001, 20'h00001, 20'hFFFFF};
        tbl[3] = '{1,  0,  0, 20'h00005, 20'h00005, 20'h00005, 20'h00005, 20'h00005};
        tbl[4] = '{1, 10, 20, 20'h00000, 20'h00000, 20'h00000, 20'hFFFFF, 20'hFFFFF};
        tbl[5] = '{0,  5,  7, 20'h80000, 20'h7FFFF, 20'h00000, 20'h00001, 20'h80000};
        tbl[6] = '{0, 31,  0, 20'h00003, 20'h00009, 20'h00009, 20'h00002, 20'h00009};
        tbl[7] = '{0,  2,  2, 20'h00001, 20'hABCDE, 20'h12345, 20'h00000, 20'hABCDE};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) l0[k][i] = '0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rd",   64'({crd, caddr_rd}), 64'd0);
        chk("reset_wr",   64'({cwr, caddr_wr, cdata_wr}), 64'd0);
        chk("reset_csel", 64'(csel), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset in idle, observed before any clock edge.
        #2 reset = 1'b0;
        #1 chk("async_idle_outputs",
               64'({busy, done, crd, cwr, csel, caddr_rd, caddr_wr}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Pass 1: directed windows on an otherwise zero map.
        for (int i = 0; i < 8; i++) begin
            b = tbl[i].r * 128 + tbl[i].c * 2;
            l0[tbl[i].k][b]      = tbl[i].s0;
            l0[tbl[i].k][b + 1]  = tbl[i].s1;
            l0[tbl[i].k][b + 64] = tbl[i].s2;
            l0[tbl[i].k][b + 65] = tbl[i].s3;
        end
        clear_log();
        run_pass("p1", -1, -1, bc, da, ab);
        pass_checks("p1", bc, da);
        for (int i = 0; i < 8; i++) begin
            o = tbl[i].r * 32 + tbl[i].c;
            chk($sformatf("vec%0d_l1", i), 64'(l1[tbl[i].k][o]), 64'(tbl[i].exp));
            chk($sformatf("vec%0d_l2", i), 64'(l2[2 * o + tbl[i].k]), 64'(tbl[i].exp));
        end
        cmp_all("p1");

        // Pass 2: random maps, stray start pulse at cycle 100.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) l0[k][i] = 20'($urandom());
        clear_log();
        run_pass("p2", 100, -1, bc, da, ab);
        pass_checks("p2", bc, da);
        cmp_all("p2");

        // Pass 3: new random maps, aborted by reset at cycle 5000.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4096; i++) l0[k][i] = 20'($urandom());
        clear_log();
        run_pass("p3", -1, 5000, bc, da, ab);
        chk("p3_aborted", 64'(ab), 64'd1);
        repeat (20) @(negedge clk);
        chk("p3_idle_after_reset", 64'({busy, crd, cwr, csel}), 64'd0);
        chk("p3_bad_wr", 64'(bad_wr), 64'd0);

        // Pass 4: fresh start after the abort must be complete and correct.
        clear_log();
        run_pass("p4", -1, -1, bc, da, ab);
        pass_checks("p4", bc, da);
        cmp_all("p4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
